// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared state encoding and helpers for the PUF key sequencer
package puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_ACK,
      ST_DONE
   } seq_state_t;

   // Width of a vote counter able to hold 0..nmeas
   function automatic int vote_width(input int nmeas);
      return $clog2(nmeas + 1);
   endfunction

   // LSB position of pair 'pair' on a packed bus of acc-bit fields
   function automatic int co_lsb(input int acc, input int pair);
      return acc * pair;
   endfunction

endpackage

// File: rtl/puf_vote_cell.sv
// rtl/puf_vote_cell.sv - per-pair majority vote counter and stability tracker
module puf_vote_cell
   import puf_pkg::*;
#(
   parameter int ACC   = 7,
   parameter int NMEAS = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clear,
   input  logic           accumulate,
   input  logic           first_run,
   input  logic           e,
   input  logic [ACC-1:0] co,
   input  logic [ACC-1:0] thresh,
   output logic           key_bit,
   output logic           mask_bit
);

   localparam int            VW      = vote_width(NMEAS);
   localparam logic [VW:0]   NMEAS_W = (VW + 1)'(NMEAS);

   logic [VW-1:0] vote;
   logic          first_e;
   logic          unstable;

   // Count ones of e, remember the first-run bit, latch instability until the next clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vote     <= '0;
         first_e  <= 1'b0;
         unstable <= 1'b0;
      end else if (clear) begin
         vote     <= '0;
         first_e  <= 1'b0;
         unstable <= 1'b0;
      end else if (accumulate) begin
         vote <= vote + VW'(e);
         if (first_run)
            first_e <= e;
         if ((co < thresh) || (!first_run && (e != first_e)))
            unstable <= 1'b1;
      end
   end

   // Strict majority: 2*vote > NMEAS, so a tie resolves to 0
   assign key_bit  = {vote, 1'b0} > NMEAS_W;
   assign mask_bit = ~unstable;

endmodule

// File: rtl/puf_key_sequencer.sv
// rtl/puf_key_sequencer.sv - runs NMEAS PUF measurements and presents key and reliability mask
module puf_key_sequencer
   import puf_pkg::*;
#(
   parameter int NROP    = 256,
   parameter int ACC     = 7,
   parameter int NMEAS   = 5,
   parameter int TIMEOUT = 4095
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_valid,
   output logic                start_ready,
   input  logic [ACC-1:0]      thresh,
   output logic                puf_req_valid,
   input  logic                puf_req_ready,
   input  logic                puf_res_valid,
   output logic                puf_res_ready,
   input  logic [NROP-1:0]     puf_e_v,
   input  logic [ACC*NROP-1:0] puf_co_v,
   output logic [NROP-1:0]     key,
   output logic [NROP-1:0]     mask,
   output logic                done_valid,
   input  logic                done_ready,
   output logic                error,
   output logic                busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   seq_state_t     state;
   logic [3:0]     meas_idx;
   logic [TW-1:0]  timer;
   logic [ACC-1:0] thresh_r;
   logic           clear_votes;
   logic           accumulate;
   logic           first_run;
   logic [NROP-1:0] key_bits;
   logic [NROP-1:0] mask_bits;

   assign clear_votes = (state == ST_IDLE) && start_valid;
   assign accumulate  = (state == ST_WAIT) && puf_res_valid;
   assign first_run   = (meas_idx == 4'd0);

   for (genvar i = 0; i < NROP; i++) begin : g_cell
      puf_vote_cell #(
         .ACC   (ACC),
         .NMEAS (NMEAS)
      ) u_cell (
         .clk        (clk),
         .rst        (rst),
         .clear      (clear_votes),
         .accumulate (accumulate),
         .first_run  (first_run),
         .e          (puf_e_v[i]),
         .co         (puf_co_v[co_lsb(ACC, i) +: ACC]),
         .thresh     (thresh_r),
         .key_bit    (key_bits[i]),
         .mask_bit   (mask_bits[i])
      );
   end

   // Sequencer FSM with all handshake and result outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         meas_idx      <= 4'd0;
         timer         <= '0;
         thresh_r      <= '0;
         start_ready   <= 1'b1;
         busy          <= 1'b0;
         puf_req_valid <= 1'b0;
         puf_res_ready <= 1'b0;
         done_valid    <= 1'b0;
         error         <= 1'b0;
         key           <= '0;
         mask          <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_valid) begin
                  thresh_r      <= thresh;
                  meas_idx      <= 4'd0;
                  error         <= 1'b0;
                  key           <= '0;
                  mask          <= '0;
                  start_ready   <= 1'b0;
                  busy          <= 1'b1;
                  puf_req_valid <= 1'b1;
                  state         <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (puf_req_ready) begin
                  puf_req_valid <= 1'b0;
                  timer         <= '0;
                  state         <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (puf_res_valid) begin
                  puf_res_ready <= 1'b1;
                  state         <= ST_ACK;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  error      <= 1'b1;
                  key        <= '0;
                  mask       <= '0;
                  done_valid <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_ACK: begin
               puf_res_ready <= 1'b0;
               if (meas_idx == 4'(NMEAS - 1)) begin
                  key        <= key_bits;
                  mask       <= mask_bits;
                  done_valid <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  meas_idx      <= meas_idx + 4'd1;
                  puf_req_valid <= 1'b1;
                  state         <= ST_REQ;
               end
            end
            ST_DONE: begin
               if (done_ready) begin
                  done_valid  <= 1'b0;
                  start_ready <= 1'b1;
                  busy        <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_key_sequencer.sv
// tb/tb_puf_key_sequencer.sv - directed table-driven bench for puf_key_sequencer
module tb_puf_key_sequencer;

   typedef struct packed {
      int          d;
      logic [6:0]  th;
      logic [19:0] e;
      logic [27:0] co;
      int          rq;
      int          rs;
      logic        no_res;
      logic [3:0]  k;
      logic [3:0]  m;
      logic        er;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       start_valid   [2];
   logic       start_ready   [2];
   logic [6:0] thresh        [2];
   logic       puf_req_valid [2];
   logic       puf_req_ready [2];
   logic       puf_res_valid [2];
   logic       puf_res_ready [2];
   logic [3:0] puf_e_v       [2];
   logic [27:0] puf_co_v     [2];
   logic [3:0] key           [2];
   logic [3:0] mask          [2];
   logic       done_valid    [2];
   logic       done_ready    [2];
   logic       error         [2];
   logic       busy          [2];

   int req_cnt  [2] = '{0, 0};
   int ack_cnt  [2] = '{0, 0};
   int done_cnt [2] = '{0, 0};
   int checks = 0;
   int errors = 0;
   vec_t vt [8];

   puf_key_sequencer #(.NROP(4), .ACC(7), .NMEAS(5), .TIMEOUT(1000)) dut_a (
      .clk(clk), .rst(rst),
      .start_valid(start_valid[0]), .start_ready(start_ready[0]), .thresh(thresh[0]),
      .puf_req_valid(puf_req_valid[0]), .puf_req_ready(puf_req_ready[0]),
      .puf_res_valid(puf_res_valid[0]), .puf_res_ready(puf_res_ready[0]),
      .puf_e_v(puf_e_v[0]), .puf_co_v(puf_co_v[0]),
      .key(key[0]), .mask(mask[0]),
      .done_valid(done_valid[0]), .done_ready(done_ready[0]),
      .error(error[0]), .busy(busy[0])
   );

   puf_key_sequencer #(.NROP(4), .ACC(7), .NMEAS(1), .TIMEOUT(20)) dut_b (
      .clk(clk), .rst(rst),
      .start_valid(start_valid[1]), .start_ready(start_ready[1]), .thresh(thresh[1]),
      .puf_req_valid(puf_req_valid[1]), .puf_req_ready(puf_req_ready[1]),
      .puf_res_valid(puf_res_valid[1]), .puf_res_ready(puf_res_ready[1]),
      .puf_e_v(puf_e_v[1]), .puf_co_v(puf_co_v[1]),
      .key(key[1]), .mask(mask[1]),
      .done_valid(done_valid[1]), .done_ready(done_ready[1]),
      .error(error[1]), .busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Handshake event counters
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (puf_req_valid[d] && puf_req_ready[d]) req_cnt[d] <= req_cnt[d] + 1;
         if (puf_res_ready[d]) ack_cnt[d] <= ack_cnt[d] + 1;
         if (done_valid[d] && done_ready[d]) done_cnt[d] <= done_cnt[d] + 1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int d, input logic [6:0] th, input logic [19:0] e,
                               input logic [27:0] co, input int rq, input int rs,
                               input logic no_res, input logic [3:0] k, input logic [3:0] m,
                               input logic er);
      vec_t v;
      v.d = d; v.th = th; v.e = e; v.co = co; v.rq = rq; v.rs = rs;
      v.no_res = no_res; v.k = k; v.m = m; v.er = er;
      return v;
   endfunction

   task automatic serve_run(input int d, input logic [3:0] e, input logic [27:0] co,
                            input int rq, input int rs, input logic no_res);
      int n;
      n = 0;
      while (!puf_req_valid[d] && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("req_valid_seen", 32'(puf_req_valid[d]), 32'd1);
      repeat (rq) begin
         @(posedge clk); #1;
      end
      puf_req_ready[d] = 1'b1;
      @(posedge clk); #1;
      puf_req_ready[d] = 1'b0;
      if (!no_res) begin
         repeat (rs) begin
            @(posedge clk); #1;
         end
         puf_e_v[d] = e;
         puf_co_v[d] = co;
         puf_res_valid[d] = 1'b1;
         n = 0;
         while (!puf_res_ready[d] && n < 2000) begin
            @(posedge clk); #1; n++;
         end
         puf_res_valid[d] = 1'b0;
         puf_e_v[d] = 4'h0;
         puf_co_v[d] = 28'h0;
         if (!puf_res_ready[d]) check("res_ready_seen", 32'd0, 32'd1);
      end
   endtask

   task automatic run_key(input vec_t v);
      int d, nm, runs, rq0, ak0, n;
      d = v.d;
      nm = (d == 0) ? 5 : 1;
      runs = v.no_res ? 1 : nm;
      rq0 = req_cnt[d];
      ak0 = ack_cnt[d];
      thresh[d] = v.th;
      start_valid[d] = 1'b1;
      @(posedge clk); #1;
      start_valid[d] = 1'b0;
      check("busy_after_start", 32'(busy[d]), 32'd1);
      check("err_cleared_on_start", 32'(error[d]), 32'd0);
      for (int r = 0; r < runs; r++)
         serve_run(d, v.e[4*r +: 4], v.co, v.rq, v.rs, v.no_res);
      n = 0;
      while (!done_valid[d] && n < 2000) begin
         @(posedge clk); #1; n++;
      end
      check("done_valid", 32'(done_valid[d]), 32'd1);
      if (v.no_res) check("timeout_wait_cycles", 32'(n), 32'd20);
      check("key", 32'(key[d]), 32'(v.k));
      check("mask", 32'(mask[d]), 32'(v.m));
      check("error", 32'(error[d]), 32'(v.er));
      check("req_count", 32'(req_cnt[d] - rq0), 32'(runs));
      check("res_ready_cycles", 32'(ack_cnt[d] - ak0), 32'(v.no_res ? 0 : nm));
   endtask

   task automatic finish_done(input int d, input logic [3:0] k, input logic [3:0] m);
      int dc0;
      dc0 = done_cnt[d];
      done_ready[d] = 1'b1;
      @(posedge clk); #1;
      done_ready[d] = 1'b0;
      check("done_dropped", 32'(done_valid[d]), 32'd0);
      check("idle_start_ready", 32'(start_ready[d]), 32'd1);
      check("idle_busy", 32'(busy[d]), 32'd0);
      check("done_handshakes", 32'(done_cnt[d] - dc0), 32'd1);
      check("key_retained", 32'(key[d]), 32'(k));
      check("mask_retained", 32'(mask[d]), 32'(m));
   endtask

   task automatic check_idle_outputs(input int d);
      check("rst_start_ready", 32'(start_ready[d]), 32'd1);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_done_valid", 32'(done_valid[d]), 32'd0);
      check("rst_req_valid", 32'(puf_req_valid[d]), 32'd0);
      check("rst_res_ready", 32'(puf_res_ready[d]), 32'd0);
      check("rst_key", 32'(key[d]), 32'd0);
      check("rst_mask", 32'(mask[d]), 32'd0);
      check("rst_error", 32'(error[d]), 32'd0);
   endtask

   initial begin
      logic [3:0] k0, m0;
      logic       stable;
      int         rq0;

      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start_valid[d] = 1'b0; thresh[d] = 7'd0;
         puf_req_ready[d] = 1'b0; puf_res_valid[d] = 1'b0;
         puf_e_v[d] = 4'h0; puf_co_v[d] = 28'h0; done_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) check_idle_outputs(d);
      rst = 1'b0;
      @(posedge clk); #1;

      // d, thresh, e {run4..run0}, co {p3,p2,p1,p0}, req delay, res delay, no_res, key, mask, error
      vt[0] = mk(1, 7'd3,   20'h0000A, {7'd0, 7'd7, 7'd2, 7'd5},        0, 1,   1'b0, 4'b1010, 4'b0101, 1'b0);
      vt[1] = mk(0, 7'd4,   {4'b0010, 4'b0011, 4'b1010, 4'b1011, 4'b0011},
                             {7'd50, 7'd4, 7'd10, 7'd9},                   1, 2,   1'b0, 4'b0011, 4'b0110, 1'b0);
      vt[2] = mk(0, 7'd0,   20'hFFFFF, 28'h0,                             3, 600, 1'b0, 4'b1111, 4'b1111, 1'b0);
      vt[3] = mk(0, 7'd127, 20'h55555, {7'd126, 7'd126, 7'd126, 7'd127}, 0, 0,   1'b0, 4'b0101, 4'b0001, 1'b0);
      vt[4] = mk(0, 7'd5,   {4'b0100, 4'b0100, 4'b0101, 4'b0111, 4'b0011},
                             {7'd5, 7'd5, 7'd5, 7'd5},                     2, 1,   1'b0, 4'b0101, 4'b1000, 1'b0);
      vt[5] = mk(1, 7'd8,   20'h00006, {7'd9, 7'd100, 7'd7, 7'd8},       0, 3,   1'b0, 4'b0110, 4'b1101, 1'b0);
      vt[6] = mk(1, 7'd0,   20'h0000F, 28'h0,                             0, 0,   1'b1, 4'b0000, 4'b0000, 1'b1);
      vt[7] = mk(1, 7'd3,   20'h0000A, {7'd0, 7'd7, 7'd2, 7'd5},        2, 5,   1'b0, 4'b1010, 4'b0101, 1'b0);

      for (int i = 0; i < 8; i++) begin
         run_key(vt[i]);
         finish_done(vt[i].d, vt[i].k, vt[i].m);
      end

      // Backpressure: hold done_ready low, keep poking start_valid
      run_key(vt[1]);
      k0 = key[0];
      m0 = mask[0];
      rq0 = req_cnt[0];
      stable = 1'b1;
      start_valid[0] = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if (key[0] !== k0 || mask[0] !== m0 || done_valid[0] !== 1'b1 || busy[0] !== 1'b1)
            stable = 1'b0;
      end
      start_valid[0] = 1'b0;
      check("backpressure_stable", 32'(stable), 32'd1);
      check("start_ignored_when_busy", 32'(req_cnt[0] - rq0), 32'd0);
      check("bp_key", 32'(k0), 32'(vt[1].k));
      finish_done(0, vt[1].k, vt[1].m);

      // Async reset during WAIT of the third run, then a clean request
      thresh[0] = 7'd0;
      start_valid[0] = 1'b1;
      @(posedge clk); #1;
      start_valid[0] = 1'b0;
      serve_run(0, 4'hF, 28'h0, 0, 1, 1'b0);
      serve_run(0, 4'hF, 28'h0, 0, 1, 1'b0);
      serve_run(0, 4'hF, 28'h0, 0, 0, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_idle_outputs(0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_reset_no_done", 32'(done_valid[0]), 32'd0);
      run_key(vt[1]);
      finish_done(0, vt[1].k, vt[1].m);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/puf_key_sequencer.md
Name: puf_key_sequencer

Overview:
- Sequences the ring-oscillator-pair PUF array through NMEAS back-to-back measurement runs using the array's req/res handshake.
- Per pair, accumulates a majority vote of the comparison bit e and flags pairs whose count difference co ever falls below a programmable threshold, or whose e disagrees between runs.
- Presents a key vector and a reliability mask to the key-derivation logic through a valid/ready handshake.

Parameters:
- NROP, 256, number of RO pairs in the array.
- ACC, 7, width of each per-pair co field.
- NMEAS, 5, measurement runs per key request (1..15).
- TIMEOUT, 4095, max cycles waiting for puf_res_valid before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start_valid  in  1  key generation request.
- start_ready  out  1  high in IDLE only.
- thresh  in  ACC  minimum acceptable co; sampled on start handshake.
- puf_req_valid  out  1  request to PUF array.
- puf_req_ready  in  1  PUF accepted request.
- puf_res_valid  in  1  PUF result available.
- puf_res_ready  out  1  result consumed.
- puf_e_v  in  NROP  per-pair comparison bits.
- puf_co_v  in  ACC*NROP  per-pair count differences; pair i at [ACC*(i+1)-1:ACC*i].
- key  out  NROP  majority-voted key bits.
- mask  out  NROP  1 = pair reliable.
- done_valid  out  1  key/mask valid.
- done_ready  in  1  consumer accepts.
- error  out  1  timeout occurred on last request; sticky until next start.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state IDLE. All outputs 0 except start_ready=1. Vote counters, unstable flags, meas_idx, timer and thresh register cleared. Reset mid-run abandons the run; no partial key is presented.
- IDLE: start_ready=1. On start_valid=1, capture thresh, clear all vote counters and unstable flags, set meas_idx=0 and error=0, go REQ.
- REQ: puf_req_valid=1 (registered). On a cycle sampling puf_req_ready=1, deassert puf_req_valid next cycle, clear timer, go WAIT.
- WAIT: timer increments each cycle.
  - On puf_res_valid=1: for each pair i, vote[i] += e[i].
  - Set unstable[i] if co[i] < thresh (unsigned), or if e[i] differs from the first-run e[i] (captured when meas_idx=0).
  - Set puf_res_ready=1, go ACK.
  - If timer reaches TIMEOUT with no puf_res_valid: set error=1, go DONE. key and mask are forced to 0.
- ACK: puf_res_ready returns to 0. Results are never sampled in ACK, so there is no double count.
  - meas_idx==NMEAS-1 -> DONE.
  - Otherwise meas_idx++, go REQ.
- DONE: key[i] = (2*vote[i] > NMEAS), so a tie gives 0. mask[i] = ~unstable[i]. done_valid=1.
  - Hold key, mask and done_valid stable until done_ready=1 is sampled, then done_valid=0 and go IDLE.
  - key and mask retain their values until the next start.
- start_valid outside IDLE is ignored.
- Vote counter width: clog2(NMEAS+1); no overflow possible.
- Round trip per run: 2 cycles of request handshake + PUF measurement latency + 2 cycles ACK.

Decomposition:
- Package puf_pkg:
  - State encoding: IDLE, REQ, WAIT, ACK, DONE.
  - Vote-width constant function.
  - Pair-slice helper for the co bus.
- Sub-module puf_vote_cell, one per pair:
  - Contains the vote counter, first-run bit, unstable flag, and key/mask bit outputs.
  - Driven by clear, accumulate and first_run strobes from the sequencer FSM.

Test Plan:
- Single run, NMEAS=1, thresh=3, model returns e=1010 and co=5,2,7,0 for 4 pairs -> key=1010, mask=0101 (pairs 1 and 3 below thresh), done_valid asserted once.
- Majority, NMEAS=5, pair 0 e sequence 1,1,0,1,0 -> key[0]=1, mask[0]=0 (disagreement). Pair 1 all 1 with co=10, thresh=4 -> key[1]=1, mask[1]=1.
- Handshake: model delays puf_req_ready 3 cycles and puf_res_valid 600 cycles -> exactly NMEAS requests issued, each res accepted once, puf_res_ready high exactly 1 cycle per run.
- Timeout: TIMEOUT=20, model never asserts res_valid -> error=1 after 20 WAIT cycles, done_valid=1, key=0, mask=0. A following start clears error.
- Backpressure: done_ready held 0 for 50 cycles -> key, mask and done_valid stable; start_valid is ignored while busy=1.
- Async reset asserted in WAIT on run 3 -> immediate IDLE with all outputs 0 and start_ready=1. A new start produces a correct key from fresh runs only.
